// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter: FSM states and the
// owner codes carried by the response-routing line.
package mem_arb_pkg;

  localparam int MEM_LATENCY_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_FILL = 2'd2,
    STORE  = 2'd3
  } arb_state_t;

  // OWNER_NONE must stay at zero so a reset owner line reads as "nobody".
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the requester handshakes and the memory port around mem_arbiter.
// master is the arbiter's view; slave is the view of caches plus memory.
interface mem_arbiter_if;

  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic [15:0] d_addr;
  logic        st_req;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        i_grant;
  logic        d_grant;
  logic        st_ack;
  logic        i_data_valid;
  logic        d_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;

  modport master (
    input  i_req, i_addr, d_req, d_addr, st_req, st_addr, st_data, mem_data_valid,
    output i_grant, d_grant, st_ack, i_data_valid, d_data_valid,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, st_req, st_addr, st_data, mem_data_valid,
    input  i_grant, d_grant, st_ack, i_data_valid, d_data_valid,
           mem_enable, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dff.sv
// Basic register cell with synchronous active-high clear.
module dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/mem_arbiter_owner_pipe.sv
// Shift line of owner codes, DEPTH stages long, so the code pushed with a read
// reaches the tail in the same cycle as that read's data valid.
module owner_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MEM_LATENCY_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t push,
  output owner_t tail
);

  logic [1:0] stage_q [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      dff #(.WIDTH(2)) u_dff (.clk(clk), .rst(rst), .d(push), .q(stage_q[g]));
    end else begin : g_body
      dff #(.WIDTH(2)) u_dff (.clk(clk), .rst(rst), .d(stage_q[g-1]), .q(stage_q[g]));
    end
  end

  assign tail = owner_t'(stage_q[DEPTH-1]);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between I-fill, D-fill and stores.
// Optional ARB_FAIR_EN: alternate I/D fills when both request together.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  arb_state_t state, next_state;
  owner_t     owner_push, owner_tail;
  logic       prefer_i;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

`ifdef ARB_FAIR_EN
  logic last_d;

  // Remembers which cache won the most recent fill so a tie goes the other way.
  always_ff @(posedge clk) begin
    if (rst)                                      last_d <= 1'b0;
    else if (state == IDLE && next_state == D_FILL) last_d <= 1'b1;
    else if (state == IDLE && next_state == I_FILL) last_d <= 1'b0;
  end

  assign prefer_i = last_d;
`else
  assign prefer_i = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.st_req)                             next_state = STORE;
        else if (bus.d_req && bus.i_req && prefer_i) next_state = I_FILL;
        else if (bus.d_req)                         next_state = D_FILL;
        else if (bus.i_req)                         next_state = I_FILL;
      end
      I_FILL:  next_state = bus.i_req ? I_FILL : IDLE;
      D_FILL:  next_state = bus.d_req ? D_FILL : IDLE;
      STORE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.i_grant    = 1'b0;
    bus.d_grant    = 1'b0;
    bus.st_ack     = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = 16'h0000;
    bus.mem_wdata  = 16'h0000;
    owner_push     = OWNER_NONE;
    case (state)
      I_FILL: begin
        bus.i_grant    = 1'b1;
        bus.mem_enable = 1'b1;
        bus.mem_addr   = bus.i_addr;
        owner_push     = OWNER_I;
      end
      D_FILL: begin
        bus.d_grant    = 1'b1;
        bus.mem_enable = 1'b1;
        bus.mem_addr   = bus.d_addr;
        owner_push     = OWNER_D;
      end
      STORE: begin
        bus.st_ack     = 1'b1;
        bus.mem_enable = 1'b1;
        bus.mem_wr     = 1'b1;
        bus.mem_addr   = bus.st_addr;
        bus.mem_wdata  = bus.st_data;
      end
      default: ;
    endcase
  end

  owner_pipe #(.DEPTH(MEM_LATENCY)) u_owner_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (owner_push),
    .tail (owner_tail)
  );

  // Responses follow whoever issued the read, not whoever holds the grant now.
  assign bus.i_data_valid = bus.mem_data_valid && (owner_tail == OWNER_I);
  assign bus.d_data_valid = bus.mem_data_valid && (owner_tail == OWNER_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vectors for mem_arbiter against a fixed-latency memory.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int LAT = 4;

  localparam logic [6:0] F_IG  = 7'b1000000;
  localparam logic [6:0] F_DG  = 7'b0100000;
  localparam logic [6:0] F_ACK = 7'b0010000;
  localparam logic [6:0] F_EN  = 7'b0001000;
  localparam logic [6:0] F_WR  = 7'b0000100;
  localparam logic [6:0] F_IDV = 7'b0000010;
  localparam logic [6:0] F_DDV = 7'b0000001;

`ifdef ARB_FAIR_EN
  localparam logic [6:0]  TIE_FLAGS = F_IG | F_EN;
  localparam logic [15:0] TIE_ADDR  = 16'h0F00;
  localparam logic [6:0]  TIE_VALID = F_IDV;
`else
  localparam logic [6:0]  TIE_FLAGS = F_DG | F_EN;
  localparam logic [15:0] TIE_ADDR  = 16'h0E00;
  localparam logic [6:0]  TIE_VALID = F_DDV;
`endif

  typedef struct {
    string       name;
    logic        rst;
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic [15:0] da;
    logic        sr;
    logic [15:0] sa;
    logic [15:0] sd;
    logic [6:0]  e_flags;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  mem_arbiter_if bus();

  mem_arbiter #(.MEM_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory answers every read exactly LAT cycles later and ignores arbiter reset.
  logic [LAT-1:0] mem_line = '0;
  always @(posedge clk) mem_line <= {mem_line[LAT-2:0], bus.mem_enable & ~bus.mem_wr};
  assign bus.mem_data_valid = mem_line[LAT-1];

  function automatic vec_t mk(string name, logic r, logic ir, logic [15:0] ia,
                              logic dr, logic [15:0] da, logic sr, logic [15:0] sa,
                              logic [15:0] sd, logic [6:0] fl, logic [15:0] ea,
                              logic [15:0] ew);
    vec_t v;
    v.name = name; v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da;
    v.sr = sr; v.sa = sa; v.sd = sd; v.e_flags = fl; v.e_addr = ea; v.e_wdata = ew;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst         = v.rst;
    bus.i_req   = v.ir;
    bus.i_addr  = v.ia;
    bus.d_req   = v.dr;
    bus.d_addr  = v.da;
    bus.st_req  = v.sr;
    bus.st_addr = v.sa;
    bus.st_data = v.sd;
  endtask

  task automatic checkOutput(input vec_t v);
    logic [6:0] got;
    @(negedge clk);
    got = {bus.i_grant, bus.d_grant, bus.st_ack, bus.mem_enable, bus.mem_wr,
           bus.i_data_valid, bus.d_data_valid};
    checks++;
    if (got !== v.e_flags || bus.mem_addr !== v.e_addr || bus.mem_wdata !== v.e_wdata) begin
      errors++;
      $display("[TB] FAIL %s: got flags=%b addr=%h wdata=%h, expected flags=%b addr=%h wdata=%h",
               v.name, got, bus.mem_addr, bus.mem_wdata, v.e_flags, v.e_addr, v.e_wdata);
    end
  endtask

  task automatic runVec(input vec_t v);
    applyStimulus(v);
    checkOutput(v);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
    bus.st_req = 1'b0; bus.st_addr = '0; bus.st_data = '0;

    // flags order: {i_grant, d_grant, st_ack, mem_enable, mem_wr, i_dv, d_dv}
    vecs.push_back(mk("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    vecs.push_back(mk("imiss_req", 0, 1, 16'h0310, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      logic [15:0] a;
      a = 16'h0310 + 16'(2 * k);
      vecs.push_back(mk($sformatf("imiss_fill%0d", k), 0, (k < 7), a, 0, 0, 0, 0, 0,
                        F_IG | F_EN | ((k >= 4) ? F_IDV : 7'b0), a, 0));
    end
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk($sformatf("imiss_tail%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, F_IDV, 0, 0));
    vecs.push_back(mk("imiss_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    vecs.push_back(mk("both_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_req",   0, 1, 16'h0400, 1, 16'h0800, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_d1",    0, 1, 16'h0400, 1, 16'h0800, 0, 0, 0, F_DG | F_EN, 16'h0800, 0));
    vecs.push_back(mk("both_d2",    0, 1, 16'h0400, 1, 16'h0800, 0, 0, 0, F_DG | F_EN, 16'h0800, 0));
    vecs.push_back(mk("both_d3",    0, 1, 16'h0400, 0, 16'h0800, 0, 0, 0, F_DG | F_EN, 16'h0800, 0));
    vecs.push_back(mk("both_gap",   0, 1, 16'h0400, 0, 16'h0800, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_i1",    0, 1, 16'h0400, 0, 0, 0, 0, 0, F_IG | F_EN | F_DDV, 16'h0400, 0));
    vecs.push_back(mk("both_i2",    0, 0, 16'h0400, 0, 0, 0, 0, 0, F_IG | F_EN | F_DDV, 16'h0400, 0));
    vecs.push_back(mk("both_dv3",   0, 0, 0, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    vecs.push_back(mk("both_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("both_iv1",   0, 0, 0, 0, 0, 0, 0, 0, F_IDV, 0, 0));
    vecs.push_back(mk("both_iv2",   0, 0, 0, 0, 0, 0, 0, 0, F_IDV, 0, 0));
    vecs.push_back(mk("both_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    vecs.push_back(mk("st_dreq",  0, 0, 0, 1, 16'h0A00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("st_d1",    0, 0, 0, 1, 16'h0A00, 1, 16'h1234, 16'hBEEF, F_DG | F_EN, 16'h0A00, 0));
    vecs.push_back(mk("st_d2",    0, 0, 0, 1, 16'h0A00, 1, 16'h1234, 16'hBEEF, F_DG | F_EN, 16'h0A00, 0));
    vecs.push_back(mk("st_d3",    0, 0, 0, 0, 16'h0A00, 1, 16'h1234, 16'hBEEF, F_DG | F_EN, 16'h0A00, 0));
    vecs.push_back(mk("st_gap",   0, 0, 0, 0, 0, 1, 16'h1234, 16'hBEEF, 0, 0, 0));
    vecs.push_back(mk("st_issue", 0, 0, 0, 0, 0, 1, 16'h1234, 16'hBEEF,
                      F_ACK | F_EN | F_WR | F_DDV, 16'h1234, 16'hBEEF));
    vecs.push_back(mk("st_dv2",   0, 0, 0, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    vecs.push_back(mk("st_dv3",   0, 0, 0, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    vecs.push_back(mk("st_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    $display("[TB] running %0d table vectors", vecs.size());
    foreach (vecs[i]) runVec(vecs[i]);

    // D reads still in flight when the grant moves to I must stay with D.
    runVec(mk("sw_dreq", 0, 0, 0, 1, 16'h0B00, 0, 0, 0, 0, 0, 0));
    runVec(mk("sw_d1",   0, 0, 0, 1, 16'h0B00, 0, 0, 0, F_DG | F_EN, 16'h0B00, 0));
    runVec(mk("sw_d2",   0, 0, 0, 1, 16'h0B00, 0, 0, 0, F_DG | F_EN, 16'h0B00, 0));
    runVec(mk("sw_d3",   0, 0, 0, 1, 16'h0B00, 0, 0, 0, F_DG | F_EN, 16'h0B00, 0));
    runVec(mk("sw_d4",   0, 0, 0, 0, 16'h0B00, 0, 0, 0, F_DG | F_EN, 16'h0B00, 0));
    runVec(mk("sw_ireq", 0, 1, 16'h0C00, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    runVec(mk("sw_i1",   0, 1, 16'h0C00, 0, 0, 0, 0, 0, F_IG | F_EN | F_DDV, 16'h0C00, 0));
    runVec(mk("sw_i2",   0, 0, 16'h0C00, 0, 0, 0, 0, 0, F_IG | F_EN | F_DDV, 16'h0C00, 0));
    runVec(mk("sw_dv4",  0, 0, 0, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    runVec(mk("sw_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(mk("sw_iv1",  0, 0, 0, 0, 0, 0, 0, 0, F_IDV, 0, 0));
    runVec(mk("sw_iv2",  0, 0, 0, 0, 0, 0, 0, 0, F_IDV, 0, 0));
    runVec(mk("sw_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of an I fill; memory still returns the three reads.
    runVec(mk("rst_ireq",  0, 1, 16'h0D00, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(mk("rst_i1",    0, 1, 16'h0D00, 0, 0, 0, 0, 0, F_IG | F_EN, 16'h0D00, 0));
    runVec(mk("rst_i2",    0, 1, 16'h0D00, 0, 0, 0, 0, 0, F_IG | F_EN, 16'h0D00, 0));
    runVec(mk("rst_assert", 1, 1, 16'h0D00, 0, 0, 0, 0, 0, F_IG | F_EN, 16'h0D00, 0));
    runVec(mk("rst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      runVec(mk($sformatf("rst_drop%0d", k), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Tie after a D fill: fair build hands it to I, fixed priority to D.
    runVec(mk("tie_dreq",  0, 0, 0, 1, 16'h0E00, 0, 0, 0, 0, 0, 0));
    runVec(mk("tie_d1",    0, 0, 0, 0, 16'h0E00, 0, 0, 0, F_DG | F_EN, 16'h0E00, 0));
    runVec(mk("tie_both",  0, 1, 16'h0F00, 1, 16'h0E00, 0, 0, 0, 0, 0, 0));
    runVec(mk("tie_grant", 0, 0, 16'h0F00, 0, 16'h0E00, 0, 0, 0, TIE_FLAGS, TIE_ADDR, 0));
    runVec(mk("tie_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(mk("tie_dv1",   0, 0, 0, 0, 0, 0, 0, 0, F_DDV, 0, 0));
    runVec(mk("tie_gap",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runVec(mk("tie_dv2",   0, 0, 0, 0, 0, 0, 0, 0, TIE_VALID, 0, 0));
    runVec(mk("tie_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
